// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//
// Register-dependency scoreboard for a single-issue in-order pipeline. Keeps
// one small counter of outstanding writes per GPR and decides each cycle
// whether the instruction held in decode may issue. Decode stalls on RAW
// hazards against in-flight writes and when its destination counter is
// already saturated, which would make the counter wrap. Write-back retirements
// release entries. A flush clears all tracking state.
//
// Optional feature:
//   SCOREBOARD_BYPASS_EN  When defined, a register whose last outstanding write
//                         retires this cycle is no longer treated as pending,
//                         so a dependent instruction issues in the same cycle.
//                         This needs a write-through register file. The rd
//                         overflow check frees one slot in the same way.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_valid / id_ready         decode handshake; issue = id_valid & id_ready
//   id_rs1/_used, id_rs2/_used  source operands of the decode instruction
//   id_rd / id_rd_we            destination of the decode instruction
//   wb_valid, wb_rd, wb_we      write-back retirement
//   flush                       clear all counters; blocks issue this cycle
//   busy                        bit i set while register i has writes in flight
//   stall_cycles                saturating count of cycles with id_valid & !id_ready
//   err                         sticky: retirement of a register with no write in flight
// -----------------------------------------------------------------------------
module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int STALL_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [4:0]          id_rs1,
  input  logic                id_rs1_used,
  input  logic [4:0]          id_rs2,
  input  logic                id_rs2_used,
  input  logic [4:0]          id_rd,
  input  logic                id_rd_we,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic                wb_we,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy,
  output logic [STALL_W-1:0]  stall_cycles,
  output logic                err
);

  localparam int               REG_W   = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] retire;   // write-back targets register i this cycle
  logic [NUM_REGS-1:0] pend;     // register i still has a write in flight
  logic [NUM_REGS-1:0] full;     // register i cannot take another write
  logic                hazard;
  logic                issue;
  logic                spurious_wb;

  // Per-register views of the current state and the write-back port.
  // NOTE: every variable assigned in a combinational block gets a value on
  // every path. A path that misses an assignment infers a latch.
  always_comb begin
    retire = '0;
    pend   = '0;
    full   = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      retire[i] = wb_valid & wb_we & (wb_rd == REG_W'(i));
      pend[i]   = (cnt[i] != '0) &
                  !(BYPASS & (cnt[i] == CNT_W'(1)) & retire[i]);
      full[i]   = (cnt[i] == CNT_MAX) & !(BYPASS & retire[i]);
    end
  end

  // x0 has bit 0 cleared in both pend and full, so x0 never causes a stall.
  assign hazard = (id_rs1_used & pend[id_rs1]) |
                  (id_rs2_used & pend[id_rs2]) |
                  (id_rd_we    & full[id_rd]);

  assign id_ready    = !rst & !flush & !hazard;
  assign issue       = id_valid & id_ready;
  assign spurious_wb = wb_valid & wb_we & (wb_rd != '0) & (cnt[wb_rd] == '0);

  // Next counter values. Issue and retire of the same register in one cycle
  // cancel out. A retire of an idle counter is an error, not an underflow.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (i == 0 || flush) begin
        cnt_nxt[i] = '0;
      end else begin
        case ({issue & id_rd_we & (id_rd == REG_W'(i)),
               retire[i] & (cnt[i] != '0)})
          2'b10:   cnt_nxt[i] = cnt[i] + CNT_W'(1);
          2'b01:   cnt_nxt[i] = cnt[i] - CNT_W'(1);
          default: cnt_nxt[i] = cnt[i];
        endcase
      end
    end
  end

  // NOTE: state updates use non-blocking assignments. Every register then
  // samples values from before the edge, whatever order the statements run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter array is a small set of flops and not a RAM, so it
      // is cleared on reset together with the rest of the state.
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      stall_cycles <= '0;
      err          <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_nxt[i];
      if (id_valid && !id_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + STALL_W'(1);
      if (spurious_wb)
        err <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 1; i < NUM_REGS; i++) busy[i] = (cnt[i] != '0);
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_issue_scoreboard
//
// Directed bench for issue_scoreboard. Inputs change 1 ns after a rising edge.
// id_ready is sampled on the falling edge. Registered outputs are sampled
// 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_issue_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_rd_we;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] busy;
  logic [15:0] stall_cycles;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_rs1       (id_rs1),
    .id_rs1_used  (id_rs1_used),
    .id_rs2       (id_rs2),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_rd_we     (id_rd_we),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_we        (wb_we),
    .flush        (flush),
    .busy         (busy),
    .stall_cycles (stall_cycles),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1;
    id_rs2 = rs2; id_rs2_used = u2; id_rd = rd; id_rd_we = we;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic we);
    wb_valid = v; wb_rd = rd; wb_we = we;
  endtask

  // Check id_ready mid-cycle, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic exp_ready);
    @(negedge clk);
    check(tag, {31'b0, id_ready}, {31'b0, exp_ready});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b0, 5'd0, 1'b0);

    // Reset held two cycles with a valid instruction in decode.
    cyc("rst_ready_c1", 1'b0);
    cyc("rst_ready_c2", 1'b0);
    check("rst_busy",  busy, 32'h0);
    check("rst_stall", {16'b0, stall_cycles}, 32'd0);
    check("rst_err",   {31'b0, err}, 32'd0);
    rst = 1'b0;

    // RAW on x5.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    cyc("raw_issue_producer", 1'b1);
    check("raw_busy5", busy, 32'h0000_0020);
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("raw_stall_c2", 1'b0);
    cyc("raw_stall_c3", 1'b0);
    set_wb(1'b1, 5'd5, 1'b1);
    cyc("raw_wb_cycle", BYP);
    set_wb(1'b0, 5'd0, 1'b0);
    cyc("raw_after_wb", 1'b1);
    check("raw_stall_cnt", {16'b0, stall_cycles}, BYP ? 32'd2 : 32'd3);
    check("raw_busy_clear", busy, 32'h0);

    // x0 is never tracked.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    cyc("x0_write", 1'b1);
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    cyc("x0_read", 1'b1);
    check("x0_busy", busy, 32'h0);

    // WAW overflow on x7 (max 3 outstanding). Issues are back to back.
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1);
    cyc("ovf_issue1", 1'b1);
    cyc("ovf_issue2", 1'b1);
    cyc("ovf_issue3", 1'b1);
    check("ovf_busy7", busy, 32'h0000_0080);
    cyc("ovf_fourth_stall", 1'b0);
    set_wb(1'b1, 5'd7, 1'b1);
    // Registered count is still 3. Only the bypass build frees the slot now.
    // After this cycle the count is 2 without bypass, 3 with bypass.
    cyc("ovf_wb_cycle", BYP);
    // Issue and retire of x7 in the same cycle leave the count unchanged.
    cyc("ovf_issue_and_wb", 1'b1);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    // Drain: 2 retirements empty x7 without bypass, 3 with bypass.
    @(posedge clk); #1;
    check("ovf_drain1_busy", busy, 32'h0000_0080);
    @(posedge clk); #1;
    check("ovf_drain2_busy", busy, BYP ? 32'h0000_0080 : 32'h0);
    if (BYP) begin
      @(posedge clk); #1;
    end
    set_wb(1'b0, 5'd0, 1'b0);
    check("ovf_drained", busy, 32'h0);
    check("ovf_no_err", {31'b0, err}, 32'd0);

    // Flush clears every counter and blocks issue.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    cyc("fl_issue3", 1'b1);
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    cyc("fl_issue9", 1'b1);
    check("fl_busy_pre", busy, 32'h0000_0208);
    flush = 1'b1;
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    cyc("fl_ready_low", 1'b0);
    flush = 1'b0;
    check("fl_busy_post", busy, 32'h0);
    check("fl_no_err", {31'b0, err}, 32'd0);
    cyc("fl_reissue4", 1'b1);
    check("fl_busy4", busy, 32'h0000_0010);

    // Spurious retirement of x12 while x4 is still in flight.
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_wb(1'b1, 5'd12, 1'b1);
    @(posedge clk); #1;
    set_wb(1'b0, 5'd0, 1'b0);
    check("sp_err_set", {31'b0, err}, 32'd1);
    check("sp_busy_kept", busy, 32'h0000_0010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sp_err_sticky", {31'b0, err}, 32'd1);
    set_wb(1'b1, 5'd4, 1'b1);
    @(posedge clk); #1;
    set_wb(1'b0, 5'd0, 1'b0);
    check("sp_busy_clear", busy, 32'h0);
    check("sp_err_still", {31'b0, err}, 32'd1);

    // Reset clears err.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_err", {31'b0, err}, 32'd0);
    check("rst2_stall", {16'b0, stall_cycles}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
